multi_led_calibrator: RTL and testbench
=======================================

Name: multi_led_calibrator

Overview:
- Parametrised successor of the two-LED pulse-oximeter controller. Supports NUM_CH LED channels, configurable ADC/DC/PGA widths, configurable thresholds and dwell.
- On start, calibrates each channel in turn:
  - DC compensation, by averaging samples and stepping dc_comp;
  - PGA gain, by stepping gain up until clipping.
- After calibration, runs a round-robin operation mode: applies each channel's stored settings and latches one ADC value per channel per dwell.
- Sits between the AFE ADC and the LED/DC-DAC/PGA control pins.

Parameters:
- NUM_CH, 2, number of LED channels (1..8)
- ADC_W, 8, ADC sample width
- DC_W, 7, DC compensation code width
- PGA_W, 4, PGA gain code width
- AVG_LOG2, 4, DC average over 2^AVG_LOG2 samples
- WIN, 32, samples per PGA min/max window
- DC_LO, 120, lower bound of the accepted DC mean
- DC_HI, 130, upper bound of the accepted DC mean
- CLIP_LO, 10, a sample below this counts as clipping
- CLIP_HI, 245, a sample above this counts as clipping
- SETTLE, 2, cycles ignored after any setting change
- DWELL, 10, cycles per channel in RUN (must be greater than SETTLE)

Ports:
- CLK  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  single-cycle pulse; begins or restarts calibration
- adc  in  ADC_W  ADC sample, valid every cycle
- led_en  out  NUM_CH  one-hot LED enable; all zero when idle
- dc_comp  out  DC_W  DC compensation code
- pga_gain  out  PGA_W  PGA gain code
- cal_busy  out  1  high during calibration
- cal_done  out  1  high in RUN
- cal_fail  out  1  sticky; DC search hit a code limit
- fail_ch  out  3  channel index that failed
- ch_value  out  NUM_CH*ADC_W  latched sample per channel; channel k occupies bits [k*ADC_W +: ADC_W]
- value_valid  out  1  one-cycle pulse when a ch_value slot updates
- value_ch  out  3  slot index updated with value_valid

Behaviour:

Clock and reset:
- Single clock CLK. rst is synchronous and active-high.
- Reset values: state IDLE; led_en, dc_comp, pga_gain, cal_busy, cal_done, cal_fail, fail_ch, ch_value, value_valid, value_ch all 0. The stored per-channel DC and PGA tables are cleared to 0.
- rst has priority over everything, including in mid-calibration and in RUN.

start:
- In any state, start aborts the current activity.
- On the next cycle: ch=0, dc_comp=0, pga_gain=0, cal_fail=0, cal_done=0, cal_busy=1; state goes to DC_SETTLE.

Per-channel calibration:
- led_en = one-hot(ch) throughout.
- DC_SETTLE: wait SETTLE cycles, then go to DC_ACC with sum cleared.
- DC_ACC:
  - Add adc to sum for 2^AVG_LOG2 cycles.
  - sum is ADC_W+AVG_LOG2 bits wide and cannot overflow.
- DC_EVAL (1 cycle), with mean = sum >> AVG_LOG2:
  - mean < DC_LO: if dc_comp == 0, go to FAIL; otherwise dc_comp-1 and go to DC_SETTLE.
  - mean > DC_HI: if dc_comp == all-ones, go to FAIL; otherwise dc_comp+1 and go to DC_SETTLE.
  - Otherwise: store dc_comp in dc_tab[ch], set pga_gain=0, go to PGA_SETTLE.
- PGA_SETTLE: wait SETTLE cycles, then go to PGA_ACC with vmin=all-ones and vmax=0.
- PGA_ACC: track vmin and vmax over WIN cycles.
- PGA_EVAL (1 cycle):
  - Clip (vmin < CLIP_LO or vmax > CLIP_HI): store pga_tab[ch] = pga_gain-1, saturating at 0.
  - No clip and pga_gain == max: store max.
  - In both cases go to NEXT_CH.
  - No clip and below max: pga_gain+1, go to PGA_SETTLE.
- NEXT_CH:
  - If ch == NUM_CH-1: go to RUN with cal_busy=0, cal_done=1.
  - Otherwise: ch+1, dc_comp=0, pga_gain=0, go to DC_SETTLE.

FAIL:
- led_en=0, cal_busy=0, cal_fail=1, fail_ch=ch.
- Hold until start or rst.

RUN:
- Channel r cycles 0..NUM_CH-1, starting at 0, spending DWELL cycles on each channel.
- Throughout a dwell: led_en = one-hot(r), dc_comp = dc_tab[r], pga_gain = pga_tab[r].
- On dwell cycle DWELL-1 (counting from 0):
  - ch_value slot r <= adc;
  - value_valid=1 and value_ch=r in the following cycle.
- r wraps from NUM_CH-1 to 0.
- ch_value holds its contents between updates.

Cycle counts:
- One DC iteration = SETTLE + 2^AVG_LOG2 + 1 cycles.
- One PGA step = SETTLE + WIN + 1 cycles.

Test Plan:
- Reset: assert rst mid-RUN -> next cycle all outputs 0 and state IDLE; a later start recalibrates from ch0.
- DC convergence: NUM_CH=2; ADC model mean = 200 - 8*dc_comp for ch0 and 180 - 8*dc_comp for ch1, no ripple -> dc_tab = {9, 7}; each step takes 19 cycles (defaults).
- PGA clip: ADC ripple of ±(4<<pga_gain) around 128 -> vmax first exceeds 245 at gain 5 -> pga_tab[ch] = 4; then RUN with cal_done=1.
- PGA max: ripple fixed at ±2 -> no clip at any gain -> pga_tab = 15.
- DC fail: ch1 mean fixed at 50 -> dc_comp walks down to 0 -> FAIL with cal_fail=1, fail_ch=1, led_en=0.
- RUN and restart: after calibration, drive adc=0x55 during ch0 dwells and 0xAA during ch1 dwells -> value_valid pulses every 10 cycles, value_ch alternates 0/1, ch_value = {0xAA, 0x55}; a start pulse mid-dwell -> next cycle cal_busy=1, cal_done=0, led_en=01, dc_comp=0.

Source files
------------

// File: rtl/multi_led_calibrator_if.sv
// AFE-side bundle of the multi-LED calibrator: ADC input, LED/DC/PGA controls,
// calibration status and the per-channel sample outputs.
interface multi_led_calibrator_if #(
    parameter int NUM_CH = 2,
    parameter int ADC_W  = 8,
    parameter int DC_W   = 7,
    parameter int PGA_W  = 4
);
    logic                    start;
    logic [ADC_W-1:0]        adc;
    logic [NUM_CH-1:0]       led_en;
    logic [DC_W-1:0]         dc_comp;
    logic [PGA_W-1:0]        pga_gain;
    logic                    cal_busy;
    logic                    cal_done;
    logic                    cal_fail;
    logic [2:0]              fail_ch;
    logic [NUM_CH*ADC_W-1:0] ch_value;
    logic                    value_valid;
    logic [2:0]              value_ch;

    // Host/AFE side: issues start, supplies ADC samples, observes controls.
    modport master (
        output start, adc,
        input  led_en, dc_comp, pga_gain, cal_busy, cal_done, cal_fail,
               fail_ch, ch_value, value_valid, value_ch
    );

    // Calibrator side.
    modport slave (
        input  start, adc,
        output led_en, dc_comp, pga_gain, cal_busy, cal_done, cal_fail,
               fail_ch, ch_value, value_valid, value_ch
    );
endinterface

// File: rtl/multi_led_calibrator.sv
// Multi-channel LED calibrator: per channel DC-compensation search then PGA
// gain ramp to just below clipping, followed by round-robin sampling in RUN.
module multi_led_calibrator #(
    parameter int NUM_CH   = 2,
    parameter int ADC_W    = 8,
    parameter int DC_W     = 7,
    parameter int PGA_W    = 4,
    parameter int AVG_LOG2 = 4,
    parameter int WIN      = 32,
    parameter int DC_LO    = 120,
    parameter int DC_HI    = 130,
    parameter int CLIP_LO  = 10,
    parameter int CLIP_HI  = 245,
    parameter int SETTLE   = 2,
    parameter int DWELL    = 10
) (
    input logic                    CLK,
    input logic                    rst,
    multi_led_calibrator_if.slave  bus
);
    typedef enum logic [3:0] {
        ST_IDLE, ST_DC_SETTLE, ST_DC_ACC, ST_DC_EVAL, ST_PGA_SETTLE,
        ST_PGA_ACC, ST_PGA_EVAL, ST_NEXT_CH, ST_RUN, ST_FAIL
    } state_t;

    localparam int SUM_W       = ADC_W + AVG_LOG2;
    localparam int AVG_N       = 1 << AVG_LOG2;
    localparam int SETTLE_LAST = (SETTLE > 0) ? SETTLE - 1 : 0;
    localparam int CNT_MAX_A   = (AVG_N > WIN) ? AVG_N : WIN;
    localparam int CNT_MAX_B   = (DWELL > SETTLE) ? DWELL : SETTLE;
    localparam int CNT_MAX     = (CNT_MAX_A > CNT_MAX_B) ? CNT_MAX_A : CNT_MAX_B;
    localparam int CNT_W       = $clog2(CNT_MAX + 1);
    localparam int CH_IW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE_LAST);
    localparam logic [CNT_W-1:0] AVG_END    = CNT_W'(AVG_N - 1);
    localparam logic [CNT_W-1:0] WIN_END    = CNT_W'(WIN - 1);
    localparam logic [CNT_W-1:0] DWELL_END  = CNT_W'(DWELL - 1);
    localparam logic [ADC_W-1:0] DC_LO_V    = ADC_W'(DC_LO);
    localparam logic [ADC_W-1:0] DC_HI_V    = ADC_W'(DC_HI);
    localparam logic [ADC_W-1:0] CLIP_LO_V  = ADC_W'(CLIP_LO);
    localparam logic [ADC_W-1:0] CLIP_HI_V  = ADC_W'(CLIP_HI);
    localparam logic [2:0]       CH_LAST    = 3'(NUM_CH - 1);

    function automatic logic [NUM_CH-1:0] one_hot(input logic [2:0] idx);
        one_hot = NUM_CH'(1'b1) << idx;
    endfunction

    state_t              state_r, state_nxt;
    logic [2:0]          ch_r, ch_nxt;
    logic [CNT_W-1:0]    cnt_r, cnt_nxt;
    logic [SUM_W-1:0]    sum_r, sum_nxt;
    logic [ADC_W-1:0]    vmin_r, vmin_nxt, vmax_r, vmax_nxt;
    logic [NUM_CH-1:0]   led_en_r, led_en_nxt;
    logic [DC_W-1:0]     dc_comp_r, dc_comp_nxt;
    logic [PGA_W-1:0]    pga_gain_r, pga_gain_nxt;
    logic                cal_busy_r, cal_busy_nxt;
    logic                cal_done_r, cal_done_nxt;
    logic                cal_fail_r, cal_fail_nxt;
    logic [2:0]          fail_ch_r, fail_ch_nxt;
    logic                value_valid_r, value_valid_nxt;
    logic [2:0]          value_ch_r, value_ch_nxt;

    logic [DC_W-1:0]     dc_tab_r  [NUM_CH];
    logic [PGA_W-1:0]    pga_tab_r [NUM_CH];
    logic [ADC_W-1:0]    val_r     [NUM_CH];

    logic                dc_we_s, pga_we_s, cap_we_s;
    logic [PGA_W-1:0]    pga_wdata_s;
    logic [ADC_W-1:0]    mean_s;
    logic                clip_s;
    logic [2:0]          ch_inc_s, run_nxt_s;
    logic [CH_IW-1:0]    ch_idx_s, run_idx_s;

    assign mean_s    = sum_r[SUM_W-1:AVG_LOG2];
    assign clip_s    = (vmin_r < CLIP_LO_V) || (vmax_r > CLIP_HI_V);
    assign ch_inc_s  = ch_r + 3'd1;
    assign run_nxt_s = (ch_r == CH_LAST) ? 3'd0 : ch_inc_s;
    assign ch_idx_s  = ch_r[CH_IW-1:0];
    assign run_idx_s = run_nxt_s[CH_IW-1:0];

    // Next-state and next-output logic for the calibration / run sequencer.
    always_comb begin
        state_nxt       = state_r;
        ch_nxt          = ch_r;
        cnt_nxt         = cnt_r;
        sum_nxt         = sum_r;
        vmin_nxt        = vmin_r;
        vmax_nxt        = vmax_r;
        led_en_nxt      = led_en_r;
        dc_comp_nxt     = dc_comp_r;
        pga_gain_nxt    = pga_gain_r;
        cal_busy_nxt    = cal_busy_r;
        cal_done_nxt    = cal_done_r;
        cal_fail_nxt    = cal_fail_r;
        fail_ch_nxt     = fail_ch_r;
        value_valid_nxt = 1'b0;
        value_ch_nxt    = value_ch_r;
        dc_we_s         = 1'b0;
        pga_we_s        = 1'b0;
        cap_we_s        = 1'b0;
        pga_wdata_s     = pga_gain_r;

        if (bus.start) begin
            state_nxt    = ST_DC_SETTLE;
            ch_nxt       = 3'd0;
            cnt_nxt      = '0;
            led_en_nxt   = one_hot(3'd0);
            dc_comp_nxt  = '0;
            pga_gain_nxt = '0;
            cal_busy_nxt = 1'b1;
            cal_done_nxt = 1'b0;
            cal_fail_nxt = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    led_en_nxt = '0;
                end
                ST_DC_SETTLE: begin
                    if (cnt_r == SETTLE_END) begin
                        state_nxt = ST_DC_ACC;
                        cnt_nxt   = '0;
                        sum_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_r + CNT_W'(1);
                    end
                end
                ST_DC_ACC: begin
                    sum_nxt = sum_r + SUM_W'(bus.adc);
                    if (cnt_r == AVG_END) begin
                        state_nxt = ST_DC_EVAL;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_r + CNT_W'(1);
                    end
                end
                ST_DC_EVAL: begin
                    // A search that runs off either end of the DAC range is unrecoverable.
                    if (mean_s < DC_LO_V) begin
                        if (dc_comp_r == '0) begin
                            state_nxt    = ST_FAIL;
                            led_en_nxt   = '0;
                            cal_busy_nxt = 1'b0;
                            cal_fail_nxt = 1'b1;
                            fail_ch_nxt  = ch_r;
                        end else begin
                            dc_comp_nxt = dc_comp_r - DC_W'(1);
                            state_nxt   = ST_DC_SETTLE;
                        end
                    end else if (mean_s > DC_HI_V) begin
                        if (dc_comp_r == {DC_W{1'b1}}) begin
                            state_nxt    = ST_FAIL;
                            led_en_nxt   = '0;
                            cal_busy_nxt = 1'b0;
                            cal_fail_nxt = 1'b1;
                            fail_ch_nxt  = ch_r;
                        end else begin
                            dc_comp_nxt = dc_comp_r + DC_W'(1);
                            state_nxt   = ST_DC_SETTLE;
                        end
                    end else begin
                        dc_we_s      = 1'b1;
                        pga_gain_nxt = '0;
                        state_nxt    = ST_PGA_SETTLE;
                    end
                end
                ST_PGA_SETTLE: begin
                    if (cnt_r == SETTLE_END) begin
                        state_nxt = ST_PGA_ACC;
                        cnt_nxt   = '0;
                        vmin_nxt  = {ADC_W{1'b1}};
                        vmax_nxt  = '0;
                    end else begin
                        cnt_nxt = cnt_r + CNT_W'(1);
                    end
                end
                ST_PGA_ACC: begin
                    vmin_nxt = (bus.adc < vmin_r) ? bus.adc : vmin_r;
                    vmax_nxt = (bus.adc > vmax_r) ? bus.adc : vmax_r;
                    if (cnt_r == WIN_END) begin
                        state_nxt = ST_PGA_EVAL;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_r + CNT_W'(1);
                    end
                end
                ST_PGA_EVAL: begin
                    // Keep the last gain that did not clip.
                    if (clip_s) begin
                        pga_we_s    = 1'b1;
                        pga_wdata_s = (pga_gain_r == '0) ? '0 : pga_gain_r - PGA_W'(1);
                        state_nxt   = ST_NEXT_CH;
                    end else if (pga_gain_r == {PGA_W{1'b1}}) begin
                        pga_we_s    = 1'b1;
                        pga_wdata_s = pga_gain_r;
                        state_nxt   = ST_NEXT_CH;
                    end else begin
                        pga_gain_nxt = pga_gain_r + PGA_W'(1);
                        state_nxt    = ST_PGA_SETTLE;
                    end
                end
                ST_NEXT_CH: begin
                    cnt_nxt = '0;
                    if (ch_r == CH_LAST) begin
                        state_nxt    = ST_RUN;
                        ch_nxt       = 3'd0;
                        cal_busy_nxt = 1'b0;
                        cal_done_nxt = 1'b1;
                        led_en_nxt   = one_hot(3'd0);
                        dc_comp_nxt  = dc_tab_r[0];
                        pga_gain_nxt = pga_tab_r[0];
                    end else begin
                        state_nxt    = ST_DC_SETTLE;
                        ch_nxt       = ch_inc_s;
                        led_en_nxt   = one_hot(ch_inc_s);
                        dc_comp_nxt  = '0;
                        pga_gain_nxt = '0;
                    end
                end
                ST_RUN: begin
                    if (cnt_r == DWELL_END) begin
                        cap_we_s        = 1'b1;
                        value_valid_nxt = 1'b1;
                        value_ch_nxt    = ch_r;
                        cnt_nxt         = '0;
                        ch_nxt          = run_nxt_s;
                        led_en_nxt      = one_hot(run_nxt_s);
                        dc_comp_nxt     = dc_tab_r[run_idx_s];
                        pga_gain_nxt    = pga_tab_r[run_idx_s];
                    end else begin
                        cnt_nxt = cnt_r + CNT_W'(1);
                    end
                end
                ST_FAIL: begin
                    led_en_nxt = '0;
                end
                default: begin
                    state_nxt  = ST_IDLE;
                    led_en_nxt = '0;
                end
            endcase
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            ch_r          <= 3'd0;
            cnt_r         <= '0;
            sum_r         <= '0;
            vmin_r        <= '0;
            vmax_r        <= '0;
            led_en_r      <= '0;
            dc_comp_r     <= '0;
            pga_gain_r    <= '0;
            cal_busy_r    <= 1'b0;
            cal_done_r    <= 1'b0;
            cal_fail_r    <= 1'b0;
            fail_ch_r     <= 3'd0;
            value_valid_r <= 1'b0;
            value_ch_r    <= 3'd0;
        end else begin
            state_r       <= state_nxt;
            ch_r          <= ch_nxt;
            cnt_r         <= cnt_nxt;
            sum_r         <= sum_nxt;
            vmin_r        <= vmin_nxt;
            vmax_r        <= vmax_nxt;
            led_en_r      <= led_en_nxt;
            dc_comp_r     <= dc_comp_nxt;
            pga_gain_r    <= pga_gain_nxt;
            cal_busy_r    <= cal_busy_nxt;
            cal_done_r    <= cal_done_nxt;
            cal_fail_r    <= cal_fail_nxt;
            fail_ch_r     <= fail_ch_nxt;
            value_valid_r <= value_valid_nxt;
            value_ch_r    <= value_ch_nxt;
        end
    end

    // Per-channel calibration tables and latched RUN samples.
    always_ff @(posedge CLK) begin
        if (rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                dc_tab_r[k]  <= '0;
                pga_tab_r[k] <= '0;
                val_r[k]     <= '0;
            end
        end else begin
            if (dc_we_s) begin
                dc_tab_r[ch_idx_s] <= dc_comp_r;
            end else begin
                dc_tab_r[ch_idx_s] <= dc_tab_r[ch_idx_s];
            end
            if (pga_we_s) begin
                pga_tab_r[ch_idx_s] <= pga_wdata_s;
            end else begin
                pga_tab_r[ch_idx_s] <= pga_tab_r[ch_idx_s];
            end
            if (cap_we_s) begin
                val_r[ch_idx_s] <= bus.adc;
            end else begin
                val_r[ch_idx_s] <= val_r[ch_idx_s];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
        assign bus.ch_value[g*ADC_W +: ADC_W] = val_r[g];
    end

    assign bus.led_en      = led_en_r;
    assign bus.dc_comp     = dc_comp_r;
    assign bus.pga_gain    = pga_gain_r;
    assign bus.cal_busy    = cal_busy_r;
    assign bus.cal_done    = cal_done_r;
    assign bus.cal_fail    = cal_fail_r;
    assign bus.fail_ch     = fail_ch_r;
    assign bus.value_valid = value_valid_r;
    assign bus.value_ch    = value_ch_r;
endmodule

// File: tb/tb_multi_led_calibrator.sv
// Directed bench for multi_led_calibrator: a small AFE model reacts to the
// LED/DC/PGA controls, expected calibration results are hand-derived constants.
module tb_multi_led_calibrator;
    localparam int M_CAL = 0, M_LOW1 = 1, M_HIGH = 2, M_RUN = 3;

    logic CLK = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;
    int   mode;
    bit   phase;
    bit   small_rip;

    always #5 CLK = ~CLK;

    multi_led_calibrator_if #(.NUM_CH(2), .ADC_W(8), .DC_W(7), .PGA_W(4)) bus ();

    multi_led_calibrator dut (.CLK(CLK), .rst(rst), .bus(bus));

    // AFE model: ch0 mean 200-8*dc, ch1 mean 180-8*dc, ripple +/-(4<<gain) or +/-2.
    function automatic logic [7:0] afe_val();
        int base, amp, v;
        amp = small_rip ? 2 : (4 << bus.pga_gain);
        if (mode == M_RUN) begin
            afe_val = (bus.led_en == 2'b01) ? 8'h55 : (bus.led_en == 2'b10) ? 8'hAA : 8'h00;
        end else if (mode == M_HIGH) begin
            afe_val = 8'd250;
        end else begin
            if (bus.led_en == 2'b10) base = (mode == M_LOW1) ? 50 : 180 - 8 * int'(bus.dc_comp);
            else                     base = 200 - 8 * int'(bus.dc_comp);
            v = phase ? base + amp : base - amp;
            if (v < 0)   v = 0;
            if (v > 255) v = 255;
            afe_val = 8'(v);
        end
    endfunction

    task automatic cyc();
        @(negedge CLK);
        phase   = ~phase;
        bus.adc = afe_val();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic wait_done(input int lim);
        int n = 0;
        while (bus.cal_done !== 1'b1 && n < lim) begin cyc(); n++; end
        chk("cal_done_reached", {31'd0, bus.cal_done}, 32'd1);
    endtask

    task automatic wait_fail(input int lim);
        int n = 0;
        while (bus.cal_fail !== 1'b1 && n < lim) begin cyc(); n++; end
        chk("cal_fail_reached", {31'd0, bus.cal_fail}, 32'd1);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.adc   = 8'd0;
        rst       = 1'b1;
        mode      = M_CAL;
        phase     = 1'b0;
        small_rip = 1'b0;
        cycles(3);
        rst = 1'b0;
        chk("rst_led_en",   32'(bus.led_en), 32'd0);
        chk("rst_dc_comp",  32'(bus.dc_comp), 32'd0);
        chk("rst_pga_gain", 32'(bus.pga_gain), 32'd0);
        chk("rst_status",   {29'd0, bus.cal_busy, bus.cal_done, bus.cal_fail}, 32'd0);
        chk("rst_ch_value", 32'(bus.ch_value), 32'd0);
        chk("rst_valid",    {31'd0, bus.value_valid}, 32'd0);
        cyc();

        // Calibration with ripple +/-(4<<gain): dc {9,7}, gain {4,4}.
        pulse_start();
        chk("start_busy",   {31'd0, bus.cal_busy}, 32'd1);
        chk("start_led_en", 32'(bus.led_en), 32'd1);
        cycles(18);
        chk("dc_step_before", 32'(bus.dc_comp), 32'd0);
        cyc();
        chk("dc_step_at19", 32'(bus.dc_comp), 32'd1);
        cycles(19);
        chk("dc_step_at38", 32'(bus.dc_comp), 32'd2);
        wait_done(2000);
        chk("done_busy_low", {31'd0, bus.cal_busy}, 32'd0);
        chk("run0_led_en",   32'(bus.led_en), 32'd1);
        chk("run0_dc_comp",  32'(bus.dc_comp), 32'd9);
        chk("run0_pga_clip", 32'(bus.pga_gain), 32'd4);

        // RUN: 0x55 on ch0 dwells, 0xAA on ch1 dwells.
        mode = M_RUN;
        cycles(10);
        chk("run_valid0",    {31'd0, bus.value_valid}, 32'd1);
        chk("run_vch0",      32'(bus.value_ch), 32'd0);
        chk("run_chval0",    32'(bus.ch_value), 32'h0055);
        chk("run1_led_en",   32'(bus.led_en), 32'd2);
        chk("run1_dc_comp",  32'(bus.dc_comp), 32'd7);
        chk("run1_pga_clip", 32'(bus.pga_gain), 32'd4);
        cyc();
        chk("run_valid_pulse", {31'd0, bus.value_valid}, 32'd0);
        cycles(8);
        chk("run_valid_early", {31'd0, bus.value_valid}, 32'd0);
        cyc();
        chk("run_valid1",  {31'd0, bus.value_valid}, 32'd1);
        chk("run_vch1",    32'(bus.value_ch), 32'd1);
        chk("run_chval1",  32'(bus.ch_value), 32'hAA55);
        chk("run_wrap_led", 32'(bus.led_en), 32'd1);

        // Restart mid-dwell with small ripple: gain reaches max on both channels.
        cycles(3);
        mode      = M_CAL;
        small_rip = 1'b1;
        pulse_start();
        chk("restart_status", {30'd0, bus.cal_busy, bus.cal_done}, 32'd2);
        chk("restart_led_en", 32'(bus.led_en), 32'd1);
        chk("restart_dc",     32'(bus.dc_comp), 32'd0);
        chk("restart_hold",   32'(bus.ch_value), 32'hAA55);
        wait_done(4000);
        chk("max0_dc",  32'(bus.dc_comp), 32'd9);
        chk("max0_pga", 32'(bus.pga_gain), 32'd15);
        cycles(10);
        chk("max1_led", 32'(bus.led_en), 32'd2);
        chk("max1_dc",  32'(bus.dc_comp), 32'd7);
        chk("max1_pga", 32'(bus.pga_gain), 32'd15);

        // Reset in RUN clears everything, including latched samples.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rstrun_led",    32'(bus.led_en), 32'd0);
        chk("rstrun_dc_pga", {21'd0, bus.dc_comp, bus.pga_gain}, 32'd0);
        chk("rstrun_status", {29'd0, bus.cal_busy, bus.cal_done, bus.cal_fail}, 32'd0);
        chk("rstrun_chval",  32'(bus.ch_value), 32'd0);
        chk("rstrun_vch",    {28'd0, bus.value_valid, bus.value_ch}, 32'd0);

        // ch1 mean stuck at 50: fails on its first DC evaluation.
        mode      = M_LOW1;
        small_rip = 1'b0;
        pulse_start();
        chk("recal_led", 32'(bus.led_en), 32'd1);
        wait_fail(2000);
        chk("faillo_ch",     32'(bus.fail_ch), 32'd1);
        chk("faillo_led",    32'(bus.led_en), 32'd0);
        chk("faillo_status", {30'd0, bus.cal_busy, bus.cal_done}, 32'd0);
        chk("faillo_dc",     32'(bus.dc_comp), 32'd0);
        cycles(5);
        chk("faillo_sticky", {31'd0, bus.cal_fail}, 32'd1);

        // Mean always high: dc_comp walks up to all-ones on ch0 then fails.
        mode = M_HIGH;
        pulse_start();
        chk("failhi_clear", {30'd0, bus.cal_fail, bus.cal_busy}, 32'd1);
        wait_fail(4000);
        chk("failhi_ch",  32'(bus.fail_ch), 32'd0);
        chk("failhi_dc",  32'(bus.dc_comp), 32'd127);
        chk("failhi_led", 32'(bus.led_en), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
